// File: rtl/lfsr_checker_if.sv
// Word stream into the PRBS checker and its status/counter outputs.
// The checker side uses the slave modport; the stream source uses master.
interface lfsr_checker_if #(
    parameter int unsigned CNT_W = 16
);
    logic             valid_in;
    logic [7:0]       data_in;
    logic             locked;
    logic             error;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] word_count;

    modport master (
        output valid_in, data_in,
        input  locked, error, err_count, word_count
    );

    modport slave (
        input  valid_in, data_in,
        output locked, error, err_count, word_count
    );
endinterface

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the 8-bit x^8+x^6+x^5+x^4+1 PRBS stream.
// Searches for LOCK_COUNT correct predictions, then checks each word and counts errors.
module lfsr_checker #(
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned LOSS_COUNT = 3,
    parameter int unsigned CNT_W      = 16
) (
    input  logic          clk,
    input  logic          reset,
    lfsr_checker_if.slave bus
);

    typedef enum logic {StSearch, StLocked} state_t;

    function automatic logic [7:0] step(input logic [7:0] r);
        return {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
    endfunction

    state_t           state_q, state_d;
    logic [7:0]       pred_q, pred_d;
    logic [3:0]       match_q, match_d;
    logic [3:0]       miss_q, miss_d;
    logic [3:0]       miss_inc;
    logic             error_q, error_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

    always_comb begin
        state_d    = state_q;
        pred_d     = pred_q;
        match_d    = match_q;
        miss_d     = miss_q;
        error_d    = 1'b0;
        err_cnt_d  = err_cnt_q;
        word_cnt_d = word_cnt_q;
        miss_inc   = miss_q + 4'd1;

        if (bus.valid_in) begin
            unique case (state_q)
                StSearch: begin
                    if (bus.data_in == 8'h00) begin
                        match_d = 4'd0;
                    end else begin
                        pred_d = step(bus.data_in);
                        // match_q counts words in the current consistent run, so the
                        // run holds match_q-1 correct predictions before this word
                        if (bus.data_in == pred_q && match_q != 4'd0) begin
                            if (match_q == 4'(LOCK_COUNT)) begin
                                state_d = StLocked;
                                match_d = 4'd0;
                                miss_d  = 4'd0;
                            end else begin
                                match_d = match_q + 4'd1;
                            end
                        end else begin
                            match_d = 4'd1;
                        end
                    end
                end
                StLocked: begin
                    pred_d = step(pred_q);
                    if (word_cnt_q != '1) word_cnt_d = word_cnt_q + CNT_W'(1);
                    if (bus.data_in == pred_q) begin
                        miss_d = 4'd0;
                    end else begin
                        error_d = 1'b1;
                        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
                        miss_d = miss_inc;
                        if (miss_inc == 4'(LOSS_COUNT)) begin
                            state_d = StSearch;
                            match_d = 4'd0;
                        end
                    end
                end
                default: state_d = StSearch;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StSearch;
            pred_q     <= 8'h00;
            match_q    <= 4'd0;
            miss_q     <= 4'd0;
            error_q    <= 1'b0;
            err_cnt_q  <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pred_q     <= pred_d;
            match_q    <= match_d;
            miss_q     <= miss_d;
            error_q    <= error_d;
            err_cnt_q  <= err_cnt_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign bus.locked     = (state_q == StLocked);
    assign bus.error      = error_q;
    assign bus.err_count  = err_cnt_q;
    assign bus.word_count = word_cnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: lock, single error, loss/relock, zero words,
// valid gaps, asynchronous reset mid-stream and counter saturation.
module tb_lfsr_checker;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [7:0] s;

    lfsr_checker_if #(.CNT_W(16)) bus ();
    lfsr_checker_if #(.CNT_W(4))  bus4 ();

    lfsr_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    lfsr_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .CNT_W(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    always #5 clk = ~clk;

    // Stimulus generator only: advances the transmitted stream.
    function automatic logic [7:0] nxt(input logic [7:0] r);
        return {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
    endfunction

    task automatic push(input logic [7:0] d);
        @(negedge clk);
        bus.valid_in = 1'b1;
        bus.data_in  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic push4(input logic [7:0] d);
        @(negedge clk);
        bus4.valid_in = 1'b1;
        bus4.data_in  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.valid_in  = 1'b0;
        bus.data_in   = 8'hxx;
        bus4.valid_in = 1'b0;
        bus4.data_in  = 8'hxx;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic lock_stream(input logic [7:0] start);
        s = start;
        repeat (5) begin
            push(s);
            s = nxt(s);
        end
    endtask

    task automatic test_reset();
        bus.valid_in  = 1'b0;
        bus.data_in   = 8'h00;
        bus4.valid_in = 1'b0;
        bus4.data_in  = 8'h00;
        reset = 1'b0;
        #12;
        n_checks++;
        if (bus.locked !== 1'b0) begin
            n_fail++; $display("FAIL reset_locked got %b want 0", bus.locked);
        end
        n_checks++;
        if (bus.error !== 1'b0) begin
            n_fail++; $display("FAIL reset_error got %b want 0", bus.error);
        end
        n_checks++;
        if (bus.err_count !== 16'd0 || bus.word_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_counts got %0d/%0d want 0/0", bus.err_count, bus.word_count);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    // 01,02,04,08 leave it searching; 0x11 is the fourth correct prediction.
    task automatic test_lock();
        s = 8'h01;
        for (int i = 0; i < 5; i++) begin
            push(s);
            s = nxt(s);
            n_checks++;
            if (bus.locked !== (i == 4) || bus.error !== 1'b0) begin
                n_fail++;
                $display("FAIL lock_seq[%0d] locked=%b error=%b want locked=%b error=0",
                         i, bus.locked, bus.error, (i == 4));
            end
        end
        push(s);  // 0x23, first checked word
        s = nxt(s);
        n_checks++;
        if (bus.word_count !== 16'd1 || bus.error !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_first_word wc=%0d err=%b want 1/0", bus.word_count, bus.error);
        end
    endtask

    task automatic test_single_error();
        push(8'h46);  // 0x47 expected
        s = nxt(s);
        n_checks++;
        if (bus.error !== 1'b1 || bus.err_count !== 16'd1 || bus.locked !== 1'b1 ||
            bus.word_count !== 16'd2) begin
            n_fail++;
            $display("FAIL single_err err=%b ec=%0d lk=%b wc=%0d want 1/1/1/2",
                     bus.error, bus.err_count, bus.locked, bus.word_count);
        end
        push(s);  // 0x8E
        s = nxt(s);
        n_checks++;
        if (bus.error !== 1'b0 || bus.err_count !== 16'd1 || bus.word_count !== 16'd3) begin
            n_fail++;
            $display("FAIL single_err_next err=%b ec=%0d wc=%0d want 0/1/3",
                     bus.error, bus.err_count, bus.word_count);
        end
    endtask

    task automatic test_loss_relock();
        do_reset();
        lock_stream(8'h01);
        push(s);
        s = nxt(s);
        for (int i = 0; i < 3; i++) begin
            push(s ^ 8'hFF);
            s = nxt(s);
            n_checks++;
            if (bus.error !== 1'b1 || bus.err_count !== 16'(i + 1) ||
                bus.locked !== (i < 2)) begin
                n_fail++;
                $display("FAIL loss[%0d] err=%b ec=%0d lk=%b want 1/%0d/%b",
                         i, bus.error, bus.err_count, bus.locked, i + 1, (i < 2));
            end
        end
        for (int i = 0; i < 5; i++) begin
            push(s);
            s = nxt(s);
            n_checks++;
            if (bus.locked !== (i == 4) || bus.error !== 1'b0 || bus.err_count !== 16'd3) begin
                n_fail++;
                $display("FAIL relock[%0d] lk=%b err=%b ec=%0d want %b/0/3",
                         i, bus.locked, bus.error, bus.err_count, (i == 4));
            end
        end
        n_checks++;
        if (bus.word_count !== 16'd4) begin
            n_fail++; $display("FAIL relock_wc got %0d want 4", bus.word_count);
        end
    endtask

    task automatic test_zero_ignore();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push(8'h00);
            n_checks++;
            if (bus.locked !== 1'b0 || bus.error !== 1'b0) begin
                n_fail++;
                $display("FAIL zero[%0d] lk=%b err=%b want 0/0", i, bus.locked, bus.error);
            end
        end
        s = 8'h23;
        for (int i = 0; i < 5; i++) begin
            push(s);
            s = nxt(s);
            n_checks++;
            if (bus.locked !== (i == 4) || bus.error !== 1'b0) begin
                n_fail++;
                $display("FAIL zero_lock[%0d] lk=%b err=%b want %b/0",
                         i, bus.locked, bus.error, (i == 4));
            end
        end
    endtask

    task automatic test_gaps();
        logic [15:0] wc;
        wc = 16'd0;
        for (int r = 0; r < 3; r++) begin
            push(s);
            s = nxt(s);
            wc++;
            n_checks++;
            if (bus.word_count !== wc || bus.error !== 1'b0 || bus.locked !== 1'b1) begin
                n_fail++;
                $display("FAIL gap_word[%0d] wc=%0d err=%b lk=%b want %0d/0/1",
                         r, bus.word_count, bus.error, bus.locked, wc);
            end
            idle();
            idle();
            n_checks++;
            if (bus.word_count !== wc || bus.error !== 1'b0) begin
                n_fail++;
                $display("FAIL gap_idle[%0d] wc=%0d err=%b want %0d/0",
                         r, bus.word_count, bus.error, wc);
            end
        end
        n_checks++;
        if (bus.err_count !== 16'd0) begin
            n_fail++; $display("FAIL gap_ec got %0d want 0", bus.err_count);
        end
    endtask

    task automatic test_mid_reset();
        push(s ^ 8'hFF);
        s = nxt(s);
        push(s);
        s = nxt(s);
        push(s ^ 8'h01);
        s = nxt(s);
        push(s);
        n_checks++;
        if (bus.err_count !== 16'd2 || bus.locked !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset ec=%0d lk=%b want 2/1", bus.err_count, bus.locked);
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.locked !== 1'b0 || bus.err_count !== 16'd0 || bus.word_count !== 16'd0 ||
            bus.error !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset lk=%b ec=%0d wc=%0d err=%b want 0/0/0/0",
                     bus.locked, bus.err_count, bus.word_count, bus.error);
        end
        @(negedge clk);
        reset = 1'b1;
        s = 8'h01;
        for (int i = 0; i < 5; i++) begin
            push(s);
            s = nxt(s);
            n_checks++;
            if (bus.locked !== (i == 4) || bus.error !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_relock[%0d] lk=%b err=%b want %b/0",
                         i, bus.locked, bus.error, (i == 4));
            end
        end
    endtask

    task automatic test_saturation();
        logic [3:0] exp_ec;
        idle();
        s = 8'h01;
        repeat (5) begin
            push4(s);
            s = nxt(s);
        end
        n_checks++;
        if (bus4.locked !== 1'b1) begin
            n_fail++; $display("FAIL sat_lock got %b want 1", bus4.locked);
        end
        for (int i = 0; i < 20; i++) begin
            push4(s ^ 8'h5A);
            s = nxt(s);
            exp_ec = (i >= 14) ? 4'd15 : 4'(i + 1);
            n_checks++;
            if (bus4.err_count !== exp_ec || bus4.locked !== 1'b1 || bus4.error !== 1'b1) begin
                n_fail++;
                $display("FAIL sat[%0d] ec=%0d lk=%b err=%b want %0d/1/1",
                         i, bus4.err_count, bus4.locked, bus4.error, exp_ec);
            end
            push4(s);
            s = nxt(s);
        end
        n_checks++;
        if (bus4.word_count !== 4'd15) begin
            n_fail++; $display("FAIL sat_wc got %0d want 15", bus4.word_count);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_single_error();
        test_loss_relock();
        test_zero_ignore();
        test_gaps();
        test_mid_reset();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Receive-side counterpart of the 8-bit pseudo-random generator (`lfsr`).
- Consumes an 8-bit pseudo-random word stream, self-synchronises to it, then checks every later word against a locally predicted sequence.
- Reports lock status, per-word error pulses and saturating error/word counters.
- Used as the loopback checker for the pseudo-random generator and for any link carrying its stream.

Parameters:
- LOCK_COUNT, 4, consecutive correctly predicted words needed to declare lock (1..15).
- LOSS_COUNT, 3, consecutive mismatches in LOCKED that force a return to SEARCH (1..15).
- CNT_W, 16, width of err_count and word_count.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- valid_in  in  1  data_in is valid this cycle.
- data_in  in  8  received pseudo-random word.
- locked  out  1  checker synchronised to stream.
- error  out  1  one-cycle pulse: last valid word mismatched while LOCKED.
- err_count  out  CNT_W  mismatches counted while LOCKED, saturating.
- word_count  out  CNT_W  valid words checked while LOCKED, saturating.

Behaviour:
- Polynomial: x^8+x^6+x^5+x^4+1, Fibonacci form.
  - step(r) = {r[6:0], r[7]^r[5]^r[4]^r[3]}.
  - The checker's step() must be bit-identical to the generator's.
- Reset (reset=0, async):
  - state=SEARCH.
  - locked=0, error=0, err_count=0, word_count=0.
  - Internal predicted word=0, match counter=0, miss counter=0.
  - Takes effect immediately, including mid-stream.
  - After reset release, resynchronisation restarts from SEARCH.
- All outputs are registered and update on the clk edge that samples valid_in=1. Latency is 1 cycle from a sampled word to its error/locked/counter update.
- valid_in=0: no state change, error=0.
- State SEARCH:
  - Valid word equal to 8'h00 (LFSR lock-up value) is ignored. State stays SEARCH and the match counter clears.
  - Otherwise, if data_in==predicted and match counter>0, the match counter increments. Any other case sets the match counter to 1 (reseed).
  - In both non-zero cases, predicted <= step(data_in), i.e. the prediction tracks the received word.
  - When the match counter reaches LOCK_COUNT, go to LOCKED: locked=1 from the next cycle, miss counter=0.
  - error is never asserted in SEARCH. Counters are frozen.
- State LOCKED: each valid word is compared with predicted.
  - Always: predicted <= step(predicted). A corrupted word never corrupts the prediction.
  - Always: word_count increments, saturating at all-ones.
  - Match: miss counter=0.
  - Mismatch:
    - error=1 for exactly one cycle.
    - err_count increments, saturating at all-ones.
    - miss counter increments.
  - Miss counter reaching LOSS_COUNT:
    - Go to SEARCH; locked=0 next cycle.
    - Match counter=0.
    - err_count and word_count hold their values until reset.
- Simultaneous: the mismatch that triggers loss still raises error and is counted.
- Back-to-back valid every cycle must be supported; throughput is one word per cycle.
- X/undefined data_in with valid_in=0 must not affect state.

Test Plan:
- Reset, then feed the clean stream 01,02,04,08,11,23,47,8E,1C,... every cycle → locked=1 one cycle after the 4th consecutive correct prediction (after word 0x11), error never 1, word_count increments per word after lock.
- Locked; replace one word 0x47 with 0x46, stream otherwise correct → single error pulse 1 cycle later, err_count=1, locked stays 1, next word 0x8E checks clean.
- Locked; corrupt 3 consecutive words → 3 error pulses, err_count=3, locked=0 after the third; resume the clean stream → relock after 4 correct predictions, err_count still 3.
- In SEARCH, feed 00,00,00 then the clean stream from 0x23 → zeros ignored, lock achieved from 0x23 onward with no error pulses.
- Locked stream with valid_in toggling 1,0,0,1 pattern → gaps produce no prediction advance and no errors.
- Assert reset low mid-stream while locked with err_count=2 → immediately locked=0, err_count=0, word_count=0; after release, relock as in the first scenario.
- Force err_count near saturation via a CNT_W=4 build with 20 mismatches interleaved so lock is not lost → err_count holds 15.
